// File: rtl/muldiv_seq_unit.sv
// Iterative HI/LO unit: MULT/MULTU shift-add and DIV/DIVU restoring divide, one bit per cycle,
// plus MTHI/MTLO writes and a combinational MFHI/MFLO read port that stalls while busy.
module muldiv_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sin,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             ack,
  output logic             busy,
  output logic             done,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MTHI = 2'b00;
  localparam logic [1:0] OP_MTLO = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div, r_neg_lo, r_neg_hi, r_div0;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_busy, r_done;

  logic               w_accept_md, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_trial;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_acc_neg;
  logic [WIDTH-1:0]   w_q_neg, w_r_neg;

  assign ack         = start & ~r_busy;
  assign stall       = (rd_req | start) & r_busy;
  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign rd_data     = rd_sel ? r_lo : r_hi;
  assign w_accept_md = ack & op[1];

  assign w_a_neg = sin & in_1[WIDTH-1];
  assign w_b_neg = sin & in_2[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~in_1 + WIDTH'(1)) : in_1;
  assign w_b_mag = w_b_neg ? (~in_2 + WIDTH'(1)) : in_2;

  // Multiply: accumulator upper half collects partial sums, lower half shifts the multiplier out.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
  assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_acc_neg = ~r_acc + (2*WIDTH)'(1);
  assign w_q_neg   = ~r_acc[WIDTH-1:0] + WIDTH'(1);
  assign w_r_neg   = ~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept_md) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(WIDTH-1)) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ack) begin
            if (op == OP_MTHI) r_hi <= in_1;
            else if (op == OP_MTLO) r_lo <= in_2;
            else begin
              r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
              r_opnd   <= w_b_mag;
              r_is_div <= op[0];
              r_neg_lo <= w_a_neg ^ w_b_neg;
              // Remainder follows the dividend; a product's sign covers both halves.
              r_neg_hi <= op[0] ? w_a_neg : (w_a_neg ^ w_b_neg);
              r_div0   <= op[0] & (in_2 == '0);
              r_cnt    <= '0;
              r_busy   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= (r_cnt == CW'(WIDTH-1)) ? '0 : r_cnt + CW'(1);
        end
        S_FIX: begin
          if (r_is_div) begin
            r_lo <= r_div0 ? '1 : (r_neg_lo ? w_q_neg : r_acc[WIDTH-1:0]);
            r_hi <= r_neg_hi ? w_r_neg : r_acc[2*WIDTH-1:WIDTH];
          end else begin
            {r_hi, r_lo} <= r_neg_lo ? w_acc_neg : r_acc;
          end
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
